evt_sync_report: RTL
====================

Name: evt_sync_report

Overview:
- Downstream consumer of the single-bit registered flag produced by the derived-clock capture stage.
- That flag is launched from a mux-generated clock, so it is asynchronous to the system clock.
- This block synchronises the flag into the system clock domain, detects rising edges and accumulates them in a saturating counter.
- It hands count snapshots to a consumer over a valid/ready handshake.

Parameters:
SYNC_STAGES, 2, synchroniser depth; legal range 2..4
CNT_W, 8, width of accumulator and reported count

Ports:
i1  input  1  clock; all state updates on posedge
i2  input  1  reset, asynchronous, active-low
i3  input  1  asynchronous flag from the upstream capture stage
i4  input  1  synchronous clear, active-high
i5  input  1  ready from consumer
o1  output 1  synchronised level of i3
o2  output 1  single-cycle rise pulse
o3  output CNT_W  reported count snapshot
o4  output 1  valid, qualifies o3
o5  output 1  sticky saturation flag

Behaviour:
- Reset (i2=0, asynchronous assert):
  - all sync stages, o1, o2, o3, o4, o5 = 0
  - accumulator = 0; FSM = IDLE
  - deassertion takes effect at the next i1 edge
- Synchroniser:
  - SYNC_STAGES-flop chain on i3; o1 = last stage.
  - A clean level change on i3 appears on o1 after SYNC_STAGES rising edges.
- Edge detect:
  - One delay register d on o1.
  - o2 is registered: o2 <= o1 & ~d.
  - o2 is high exactly one cycle, one cycle after o1 rises.
  - A falling edge produces no pulse.
  - Back-to-back toggles shorter than the synchroniser resolution may be lost; this is acceptable.
- Accumulator acc (CNT_W bits):
  - Increments by 1 on each cycle where o2=1.
  - Saturates at 2^CNT_W-1.
  - An increment attempted at max leaves acc at max and sets o5=1.
  - o5 stays 1 until i4 or reset.
- Report FSM, states IDLE and HOLD:
  - IDLE: if acc!=0, then o3<=acc, o4<=1, acc<=o2 (a rise in the same cycle is kept, never lost), go to HOLD. Otherwise hold state, o4=0.
  - HOLD: o4=1 and o3 stable until i5=1.
  - HOLD with i5=1: transfer complete; o4<=0, go to IDLE. Earliest next snapshot is one cycle later.
  - HOLD: acc keeps accumulating independently; saturation rules apply.
  - o4 never drops without i5, except on i4 or reset.
- Clear (i4=1), dominant over all other events in the same cycle:
  - acc<=0, o4<=0, o3<=0, o5<=0, FSM<=IDLE
  - synchroniser, d and o2 are unaffected
  - a rise pulse in the clear cycle is discarded
- Latency:
  - i3 rise to o2 pulse: SYNC_STAGES+1 edges.
  - Pulse to o4 assertion with FSM in IDLE and acc previously 0: 2 edges (acc update, then snapshot).
- Simultaneous events:
  - Snapshot load and rise in the same cycle: o3 gets the old acc; acc becomes 1.
  - i5 sampled while o4=0: ignored.

Test Plan:
- Reset check: drive i2=0 mid-operation with o4=1 and acc=5 -> all outputs 0 immediately (before any clock edge); after release, no spurious o2.
- Sync latency: SYNC_STAGES=2, raise i3 at edge 0 and hold -> o1=1 after edge 2, o2=1 only after edge 3; o3=1, o4=1 after edge 5.
- Backpressure: i5=0, three separated i3 pulses -> first report o3=1 held with o4=1; after i5=1 for one cycle, o4 drops, and the next cycle reports o3=2.
- Saturation: CNT_W=4, i5=0, 17 rises while in HOLD -> acc=15, o5=1; after i5, o3=15; o5 stays 1 until i4.
- Coincidence: rise pulse in the same cycle as an IDLE snapshot with acc=3 -> o3=3, next report o3=1.
- Clear dominance: i4=1 in the same cycle as o2=1 and i5=1 -> acc=0, o4=0, o5=0, FSM IDLE; no report follows.

Source files
------------

// File: rtl/evt_sync_report.sv
// evt_sync_report: synchronise an async flag, count its rising edges (saturating)
// and hand count snapshots to a consumer over valid/ready.
module evt_sync_report #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             i1,
  input  logic             i2,
  input  logic             i3,
  input  logic             i4,
  input  logic             i5,
  output logic             o1,
  output logic             o2,
  output logic [CNT_W-1:0] o3,
  output logic             o4,
  output logic             o5
);
  typedef enum logic {IDLE, HOLD} state_t;
  localparam logic [CNT_W-1:0] MAX = '1;
  state_t state, state_nx;
  logic [SYNC_STAGES-1:0] sync;
  logic d, sat_hit, snap, o5_nx;
  logic [CNT_W-1:0] acc, acc_nx, acc_inc, o3_nx;
  assign o1 = sync[SYNC_STAGES-1];
  assign o4 = state == HOLD;
  always_ff @(posedge i1 or negedge i2)
    if (!i2) begin
      sync <= '0;
      d    <= 1'b0;
      o2   <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], i3};
      d    <= o1;
      o2   <= o1 & ~d;
    end
  // clear dominates; an IDLE snapshot restarts acc with any same-cycle rise
  always_comb begin
    sat_hit  = o2 && acc == MAX;
    acc_inc  = (o2 && !sat_hit) ? acc + 1'b1 : acc;
    snap     = state == IDLE && acc != '0;
    state_nx = i4 ? IDLE : snap ? HOLD : (state == HOLD && i5) ? IDLE : state;
    acc_nx   = i4 ? '0 : snap ? CNT_W'(o2) : acc_inc;
    o3_nx    = i4 ? '0 : snap ? acc : o3;
    o5_nx    = !i4 && (o5 || sat_hit);
  end
  always_ff @(posedge i1 or negedge i2)
    if (!i2) begin
      state <= IDLE;
      acc   <= '0;
      o3    <= '0;
      o5    <= 1'b0;
    end else begin
      state <= state_nx;
      acc   <= acc_nx;
      o3    <= o3_nx;
      o5    <= o5_nx;
    end
endmodule
